dot_accumulator: RTL and testbench

DOT_ACCUMULATOR -- requirements
Module: dot_accumulator

---
 rtl/drum_pkg.sv | 13 +
 rtl/dot_accumulator_sat_add.sv | 29 ++
 rtl/dot_accumulator.sv | 101 ++++++++++
 tb/tb_dot_accumulator.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/drum_pkg.sv
// Shared types and default sizing for the dot-product accumulator.
package drum_pkg;

   localparam int DEF_PW  = 8;
   localparam int DEF_AW  = 16;
   localparam int DEF_LEN = 8;

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_DONE = 1'b1
   } state_e;

endpackage

// File: rtl/dot_accumulator_sat_add.sv
// Saturating signed add of a narrow product onto a wide accumulator.
module sat_add
   import drum_pkg::*;
#(
   parameter int PW = DEF_PW,
   parameter int AW = DEF_AW
) (
   input  logic [AW-1:0] a,
   input  logic [PW-1:0] b,
   output logic [AW-1:0] sum,
   output logic          ovf
);

   // One guard bit is enough: |a + b| never exceeds twice the AW range.
   logic [AW:0] full;

   assign full = {a[AW-1], a} + {{(AW + 1 - PW){b[PW-1]}}, b};

   // Clamp toward the sign of the true result when the guard bit disagrees.
   always_comb begin
      sum = full[AW-1:0];
      ovf = 1'b0;
      if (full[AW] != full[AW-1]) begin
         ovf = 1'b1;
         sum = full[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
      end
   end

endmodule

// File: rtl/dot_accumulator.sv
// Accumulates a stream of signed products into one saturated dot product
// per vector, then holds the result until the consumer takes it.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_ACC  | taking product beats; outputs read 0
//   ST_DONE | result held on out_*; input beats ignored until out_ready
module dot_accumulator
   import drum_pkg::*;
#(
   parameter int PW  = DEF_PW,
   parameter int AW  = DEF_AW,
   parameter int LEN = DEF_LEN
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [PW-1:0] in_prod,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_sum,
   output logic [7:0]    out_count,
   output logic          out_ovf
);

   localparam logic [7:0] LEN8 = 8'(LEN);

   state_e        state_q, state_d;
   logic [AW-1:0] acc_q, acc_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          ovf_q, ovf_d;

   logic [AW-1:0] add_sum;
   logic          add_ovf;
   logic [7:0]    cnt_inc;
   logic          accept;

   sat_add #(.PW(PW), .AW(AW)) u_sat_add (
      .a   (acc_q),
      .b   (in_prod),
      .sum (add_sum),
      .ovf (add_ovf)
   );

   // Ready is held low while reset is asserted, even though the state is ACC.
   assign in_ready = rst_n & (state_q == ST_ACC);
   assign accept   = in_valid & in_ready;
   assign cnt_inc  = cnt_q + 8'd1;

   // Next-state and accumulator update.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_ACC: begin
            if (accept) begin
               acc_d = add_sum;
               cnt_d = cnt_inc;
               ovf_d = ovf_q | add_ovf;
               if (in_last || (cnt_inc == LEN8)) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_ACC;
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = ST_ACC;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_ACC;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   assign out_valid = (state_q == ST_DONE);
   assign out_sum   = out_valid ? acc_q : '0;
   assign out_count = out_valid ? cnt_q : 8'd0;
   assign out_ovf   = out_valid & ovf_q;

endmodule

// File: tb/tb_dot_accumulator.sv
module tb_dot_accumulator;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_prod;
   logic       in_last;
   logic       out_ready;

   logic        in_ready_a, out_valid_a, out_ovf_a;
   logic [15:0] out_sum_a;
   logic [7:0]  out_count_a;
   logic        in_ready_b, out_valid_b, out_ovf_b;
   logic [9:0]  out_sum_b;
   logic [7:0]  out_count_b;

   int compared = 0;
   int errors   = 0;

   // Default sizing (PW=8, AW=16, LEN=8)
   dot_accumulator dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid_a),
      .out_ready(out_ready), .out_sum(out_sum_a), .out_count(out_count_a),
      .out_ovf(out_ovf_a)
   );

   // Narrow accumulator (AW=10) to reach saturation quickly
   dot_accumulator #(.PW(8), .AW(10), .LEN(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid_b),
      .out_ready(out_ready), .out_sum(out_sum_b), .out_count(out_count_b),
      .out_ovf(out_ovf_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural reference model ----------------
   int m_acc_a, m_acc_b, m_cnt;
   bit m_ovf_a, m_ovf_b, m_done;

   function automatic int sat(input int a, input int p, input int aw, output bit o);
      int s, hi, lo;
      s  = a + p;
      hi = (1 << (aw - 1)) - 1;
      lo = -(1 << (aw - 1));
      o  = 1'b0;
      if (s > hi) begin s = hi; o = 1'b1; end
      if (s < lo) begin s = lo; o = 1'b1; end
      return s;
   endfunction

   task automatic model_clear();
      m_acc_a = 0; m_acc_b = 0; m_cnt = 0;
      m_ovf_a = 0; m_ovf_b = 0; m_done = 0;
   endtask

   initial model_clear();

   always @(posedge clk) begin
      bit oa, ob;
      if (!rst_n) begin
         model_clear();
      end else if (m_done) begin
         if (out_ready) model_clear();
      end else if (in_valid) begin
         m_acc_a = sat(m_acc_a, int'($signed(in_prod)), 16, oa);
         m_acc_b = sat(m_acc_b, int'($signed(in_prod)), 10, ob);
         m_ovf_a = m_ovf_a | oa;
         m_ovf_b = m_ovf_b | ob;
         m_cnt   = m_cnt + 1;
         if (in_last || m_cnt == 8) m_done = 1'b1;
      end
   end

   task automatic chk(input string name, input logic signed [31:0] act,
                      input logic signed [31:0] exp);
      compared++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of both DUTs against the model.
   always @(negedge clk) begin
      chk("in_ready_a", in_ready_a, rst_n && !m_done);
      chk("in_ready_b", in_ready_b, rst_n && !m_done);
      chk("out_valid_a", out_valid_a, m_done);
      chk("out_valid_b", out_valid_b, m_done);
      chk("out_sum_a", $signed(out_sum_a), m_done ? m_acc_a : 0);
      chk("out_sum_b", $signed(out_sum_b), m_done ? m_acc_b : 0);
      chk("out_count_a", out_count_a, m_done ? m_cnt : 0);
      chk("out_count_b", out_count_b, m_done ? m_cnt : 0);
      chk("out_ovf_a", out_ovf_a, m_done ? m_ovf_a : 0);
      chk("out_ovf_b", out_ovf_b, m_done ? m_ovf_b : 0);
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] p, input logic l);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_prod  = p;
      in_last  = l;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (in_ready_a) begin
            ok = 1'b1;
            tick();
            break;
         end
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("send_accepted", ok, 1);
   endtask

   task automatic wait_done(input string name, input int sa, input int sb,
                            input int cnt, input bit oa, input bit ob,
                            input int lat, input bit rel);
      int waited;
      waited = -1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (out_valid_a) begin
            waited = n;
            break;
         end
         tick();
      end
      chk({name, "_latency"}, waited, lat);
      chk({name, "_sum_a"}, $signed(out_sum_a), sa);
      chk({name, "_sum_b"}, $signed(out_sum_b), sb);
      chk({name, "_model_sum_a"}, m_acc_a, sa);
      chk({name, "_count"}, out_count_a, cnt);
      chk({name, "_ovf_a"}, out_ovf_a, oa);
      chk({name, "_ovf_b"}, out_ovf_b, ob);
      if (rel) out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;

      // reset held for 3 cycles
      repeat (3) begin
         @(negedge clk);
         chk("rst_out_valid", out_valid_a, 0);
         chk("rst_out_sum", $signed(out_sum_a), 0);
         chk("rst_out_count", out_count_a, 0);
         chk("rst_out_ovf", out_ovf_a, 0);
         chk("rst_in_ready", in_ready_a, 0);
      end
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_in_ready", in_ready_a, 1);
      tick();

      // full-length vector: 8 x 0x09, result visible right after the 8th beat
      repeat (8) send(8'h09, 1'b0);
      wait_done("full", 72, 72, 8, 0, 0, 0, 1);

      // early last
      send(8'd5, 1'b0);
      send(8'hFD, 1'b0);
      send(8'd10, 1'b1);
      wait_done("early", 12, 12, 3, 0, 0, 0, 1);

      // saturation in the AW=10 instance, positive then negative
      repeat (8) send(8'h7F, 1'b0);
      wait_done("sat_pos", 1016, 511, 8, 0, 1, 0, 1);
      repeat (8) send(8'h80, 1'b0);
      wait_done("sat_neg", -1024, -512, 8, 0, 1, 0, 1);

      // backpressure: hold result with beats offered
      send(8'd1, 1'b0);
      send(8'd2, 1'b1);
      wait_done("bp", 3, 3, 2, 0, 0, 0, 0);
      in_valid = 1'b1;
      in_prod  = 8'h55;
      repeat (5) begin
         @(negedge clk);
         chk("bp_hold_sum", $signed(out_sum_a), 3);
         chk("bp_hold_ready", in_ready_a, 0);
         chk("bp_hold_valid", out_valid_a, 1);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // single-beat vector starts from a cleared accumulator
      send(8'hFC, 1'b1);
      wait_done("single", -4, -4, 1, 0, 0, 0, 1);

      // reset mid-vector discards the partial sum
      repeat (3) send(8'd7, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      send(8'd2, 1'b0);
      send(8'd3, 1'b1);
      wait_done("midrst", 5, 5, 2, 0, 0, 0, 1);

      // randomized traffic, with occasional resets
      repeat (600) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_prod   = 8'($urandom_range(0, 255));
         in_last   = ($urandom_range(0, 4) == 0);
         out_ready = ($urandom_range(0, 1) == 1);
         rst_n     = ($urandom_range(0, 59) != 0);
         tick();
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      rst_n     = 1'b1;
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
      $finish;
   end

endmodule
